// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//
// Bundle of the request/response handshakes between two requesters and the
// shared-ALU arbiter.
//
//   req0_* / req1_*   : valid/ready request handshake plus 32-bit operands
//                       a, b and a 4-bit op code (requester -> arbiter)
//   resp0_* / resp1_* : valid/ready response handshake plus the 32-bit
//                       result and zero flag (arbiter -> requester)
//
// Modports:
//   master : the requester side (drives requests, consumes responses)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface alu_arbiter_if;

  // Requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;
  logic        resp0_valid;
  logic        resp0_ready;
  logic [31:0] resp0_result;
  logic        resp0_zero;

  // Requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp1_result;
  logic        resp1_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, resp1_ready,
    input  req0_ready, resp0_valid, resp0_result, resp0_zero,
    input  req1_ready, resp1_valid, resp1_result, resp1_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, resp1_ready,
    output req0_ready, resp0_valid, resp0_result, resp0_zero,
    output req1_ready, resp1_valid, resp1_result, resp1_zero
  );

endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share a single 32-bit ALU. One operation is in flight at a
// time: IDLE (arbitrate/accept) -> EXEC (compute, register result) ->
// RESP (hold result until the owner consumes it) -> IDLE.
//
// Parameters:
//   RR_EN      : 1 = round-robin between requesters, 0 = fixed priority
//                with requester 0 highest.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : request/response handshakes for both requesters
//   busy       : high whenever the FSM is not in IDLE
//   illegal_op : one-cycle pulse in the cycle after an undefined op code
//                is accepted
//
// Op codes: AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111 (signed) NOR=1100.
// Any other code yields result 0 with zero flag set.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic          illegal_op
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester-indexed views of the interface signals
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_op;
  logic [1:0]       resp_ready;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign req_a      = {bus.req1_a, bus.req0_a};
  assign req_b      = {bus.req1_b, bus.req0_b};
  assign req_op     = {bus.req1_op, bus.req0_op};
  assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

  // State
  state_t           state_reg;
  logic             owner_reg;       // requester that owns the in-flight op
  logic             last_grant_reg;  // requester granted most recently
  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [3:0]       op_reg;
  logic [1:0]       resp_valid_reg;
  logic [1:0][31:0] resp_result_reg;
  logic [1:0]       resp_zero_reg;
  logic             busy_reg;
  logic             illegal_reg;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic grant_id;
  logic accept;

  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (req_valid == 2'b11 && RR_EN != 0) begin
      // Contention: the requester not served last wins. last_grant_reg
      // resets to 1 so requester 0 wins the first contention.
      grant_id = ~last_grant_reg;
    end
  end

  assign accept = (state_reg == IDLE) && (req_valid != 2'b00);

  assign bus.req0_ready = accept && (grant_id == 1'b0);
  assign bus.req1_ready = accept && (grant_id == 1'b1);

  // -------------------------------------------------------------------------
  // Shared ALU, operating on the latched operands
  // -------------------------------------------------------------------------
  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_is_legal = 1'b1;
      default:                                      op_is_legal = 1'b0;
    endcase
  endfunction

  logic [31:0] alu_result;
  logic        alu_zero;

  always_comb begin
    alu_result = 32'h0;
    case (op_reg)
      OP_AND: alu_result = a_reg & b_reg;
      OP_OR:  alu_result = a_reg | b_reg;
      OP_ADD: alu_result = a_reg + b_reg;
      OP_SUB: alu_result = a_reg - b_reg;
      OP_SLT: alu_result = {31'h0, ($signed(a_reg) < $signed(b_reg))};
      OP_NOR: alu_result = ~(a_reg | b_reg);
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_grant_reg  <= 1'b1;
      a_reg           <= 32'h0;
      b_reg           <= 32'h0;
      op_reg          <= 4'h0;
      resp_valid_reg  <= 2'b00;
      resp_result_reg <= '0;
      resp_zero_reg   <= 2'b00;
      busy_reg        <= 1'b0;
      illegal_reg     <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg          <= req_a[grant_id];
            b_reg          <= req_b[grant_id];
            op_reg         <= req_op[grant_id];
            owner_reg      <= grant_id;
            last_grant_reg <= grant_id;
            illegal_reg    <= !op_is_legal(req_op[grant_id]);
            busy_reg       <= 1'b1;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          resp_result_reg[owner_reg] <= alu_result;
          resp_zero_reg[owner_reg]   <= alu_zero;
          resp_valid_reg[owner_reg]  <= 1'b1;
          state_reg                  <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response; returning to IDLE
          // here means the next acceptance is at the following edge.
          if (resp_ready[owner_reg]) begin
            resp_valid_reg[owner_reg] <= 1'b0;
            busy_reg                  <= 1'b0;
            state_reg                 <= IDLE;
          end
        end
        default: begin
          resp_valid_reg <= 2'b00;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign bus.resp0_valid  = resp_valid_reg[0];
  assign bus.resp1_valid  = resp_valid_reg[1];
  assign bus.resp0_result = resp_result_reg[0];
  assign bus.resp1_result = resp_result_reg[1];
  assign bus.resp0_zero   = resp_zero_reg[0];
  assign bus.resp1_zero   = resp_zero_reg[1];
  assign busy             = busy_reg;
  assign illegal_op       = illegal_reg;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester K presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  arbiter accepts requester K this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  operands of requester K.
REQ-007 SHALL have ports req0_op / req1_op  input  4  ALU op code of requester K.
REQ-008 SHALL have ports resp0_valid / resp1_valid  output  1  result available for requester K.
REQ-009 SHALL have ports resp0_ready / resp1_ready  input  1  requester K consumes its result.
REQ-010 SHALL have ports resp0_result / resp1_result  output  32, and resp0_zero / resp1_zero  output  1  registered result and zero flag.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port illegal_op  output  1  one-cycle pulse when an accepted op code is not defined.

Function
REQ-013 SHALL share one ALU instance between both requesters, with op codes AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111 (signed), NOR=1100; ADD/SUB wrap modulo 2^32.
REQ-014 SHALL treat any other op code as result 32'h0 with zero=1, and SHALL pulse illegal_op in the cycle following its acceptance.
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 SHALL, in IDLE, drive reqK_ready=1 only for the granted requester K and 0 for the other; in EXEC and RESP both ready outputs SHALL be 0.
REQ-017 SHALL grant the sole valid requester when only one is valid; when both are valid, the requester not granted last (RR_EN=1) or requester 0 (RR_EN=0).
REQ-018 SHALL initialise the round-robin pointer so requester 0 wins the first contention after reset; the pointer SHALL update only on acceptance.
REQ-019 SHALL, on acceptance (valid&ready at edge t), latch operands, op and owner ID, and move IDLE->EXEC.
REQ-020 SHALL, at edge t+1, register the ALU result and zero flag, move EXEC->RESP, and assert resp_valid of the owner only, from t+1.
REQ-021 SHALL hold respK_valid, respK_result and respK_zero stable until respK_ready=1 is sampled; at that edge it SHALL move RESP->IDLE and deassert respK_valid.
REQ-022 SHALL not accept a new request in the cycle that a response completes; the earliest next acceptance is one cycle later (3 cycles per operation minimum).
REQ-023 SHALL ignore respK_ready of the non-owner and SHALL ignore reqK_* inputs outside IDLE.
REQ-024 SHALL keep the non-owner respK_valid=0 and both respK_result at the last registered value.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, the round-robin pointer to favour requester 0, all resp valid flags 0, both results 32'h0, both zero flags 0, busy 0 and illegal_op 0.
REQ-026 SHALL discard any in-flight operation on reset; no response SHALL be produced for it after reset release.
REQ-027 SHALL begin arbitration on the first rising edge after rst_n returns high.

Verification
REQ-028 Single ADD: req0 a=5, b=7, op=0010, accepted at edge t -> resp0_valid=1 from t+1 with result=12, zero=0, resp1_valid=0.
REQ-029 Zero flag and back-pressure: req1 SUB a=3, b=3 with resp1_ready held low 4 cycles -> result=0, zero=1 held stable, busy=1, no acceptance until resp1_ready=1.
REQ-030 Contention with RR_EN=1:
- Both valid with req0 SLT a=32'hFFFFFFFF, b=1 and req1 OR a=F0, b=0F.
- Required: req0 is served first with result=1.
- Required: req1 is served next with result=32'hFF.
- Required: with both again valid, req1 is not granted twice in a row; req0 is granted.
REQ-031 Fixed priority with RR_EN=0: both continuously valid -> req0 is granted on every arbitration.
REQ-032 Illegal op: op=1111 -> illegal_op pulses for one cycle, result=0, zero=1.
REQ-033 Reset mid-EXEC: rst_n driven low during EXEC -> all outputs take their reset values asynchronously, and no resp_valid appears after release.
